// File: rtl/hb_ram_arbiter_pkg.sv
// hb_ram_arbiter_pkg: shared types and store lane helper for the high-speed bus RAM arbiter
package hb_ram_arbiter_pkg;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} store_width_t;
   typedef enum logic [1:0] {IDLE, CORE_RD, EXT_RD} arb_state_t;
   // Returns {mask, lane_data}; width 2'b11 falls through to a full word
   function automatic logic [35:0] store_mask_gen(input logic [1:0] width, input logic [1:0] addr,
                                                  input logic [31:0] wdata);
      return width == BYTE ? {4'b0001 << addr, {4{wdata[7:0]}}}
           : width == HALF ? {addr[1] ? 4'b1100 : 4'b0011, {2{wdata[15:0]}}}
           : {4'b1111, wdata};
   endfunction
endpackage

// File: rtl/hb_store_lane.sv
// hb_store_lane: converts a store width and byte offset into a RAM byte mask and lane-placed data
module hb_store_lane
   import hb_ram_arbiter_pkg::*;
(
   input  logic [1:0]  width,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [3:0]  mask,
   output logic [31:0] lane_data
);
   always_comb {mask, lane_data} = store_mask_gen(width, addr, wdata);
endmodule

// File: rtl/hb_ram_arbiter.sv
// hb_ram_arbiter: shares the single-port data RAM between the core data port and one external master
module hb_ram_arbiter
   import hb_ram_arbiter_pkg::*;
#(
   parameter int RAM_AW       = 12,
   parameter int EXT_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_sync,
   input  logic              core_read,
   input  logic              core_write,
   input  logic [1:0]        core_write_width,
   input  logic [31:0]       core_raddr,
   input  logic [31:0]       core_waddr,
   input  logic [31:0]       core_wdata,
   output logic [31:0]       core_rdata,
   output logic              core_stall_req,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [31:0]       ext_addr,
   input  logic [3:0]        ext_wmask,
   input  logic [31:0]       ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [31:0]       ext_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [3:0]        ram_wmask,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);
   localparam int WCW = $clog2(EXT_MAX_WAIT + 1);
   localparam logic [WCW-1:0] WMAX = WCW'(EXT_MAX_WAIT);
   arb_state_t state;
   logic [WCW-1:0] wait_cnt;
   logic wr_done, core_wr, core_any, idle, ext_win, cw_win, cr_win;
   logic [3:0] lane_mask;
   logic [31:0] lane_data;
   logic unused_addr_bits;
   hb_store_lane u_lane (
      .width(core_write_width), .addr(core_waddr[1:0]), .wdata(core_wdata),
      .mask(lane_mask), .lane_data(lane_data)
   );
   // wr_done marks the store half of a combined load+store as already written
   assign core_wr  = core_write && !wr_done;
   assign core_any = core_read || core_write;
   assign idle     = state == IDLE && !rst_sync;
   assign ext_win  = idle && ext_req && (wait_cnt == WMAX || !(core_wr || core_read));
   assign cw_win   = idle && !ext_win && core_wr;
   assign cr_win   = idle && !ext_win && !core_wr && core_read;
   assign ext_gnt    = ext_win;
   assign ext_rvalid = !rst_sync && state == EXT_RD;
   assign ext_rdata  = ext_rvalid ? ram_rdata : '0;
   assign core_rdata = (!rst_sync && state == CORE_RD) ? ram_rdata : '0;
   assign core_stall_req = (ext_win || ext_rvalid) ? core_any : idle && core_read;
   assign ram_en    = ext_win || cw_win || cr_win;
   assign ram_we    = ext_win ? ext_we : cw_win;
   assign ram_wmask = ext_win ? (ext_we ? ext_wmask : 4'b0) : cw_win ? lane_mask : 4'b0;
   assign ram_addr  = ext_win ? ext_addr[RAM_AW+1:2] : cw_win ? core_waddr[RAM_AW+1:2]
                    : cr_win ? core_raddr[RAM_AW+1:2] : '0;
   assign ram_wdata = (ext_win && ext_we) ? ext_wdata : cw_win ? lane_data : '0;
   assign unused_addr_bits = ^{ext_addr[31:RAM_AW+2], ext_addr[1:0], core_raddr[31:RAM_AW+2],
                               core_raddr[1:0], core_waddr[31:RAM_AW+2]};
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state    <= IDLE;
         wait_cnt <= '0;
         wr_done  <= 1'b0;
      end else begin
         state    <= (ext_win && !ext_we) ? EXT_RD : cr_win ? CORE_RD : IDLE;
         wait_cnt <= (!ext_req || ext_win) ? '0 : wait_cnt == WMAX ? wait_cnt : wait_cnt + 1'b1;
         wr_done  <= core_read && (cw_win || (wr_done && !cr_win));
      end
   end
endmodule

// File: tb/tb_hb_ram_arbiter.sv
// tb_hb_ram_arbiter: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_hb_ram_arbiter;
   localparam int AW = 12;
   localparam int MAXW = 4;
   logic clk = 0, rst_sync = 1;
   logic core_read = 0, core_write = 0;
   logic [1:0] core_write_width = 0;
   logic [31:0] core_raddr = 0, core_waddr = 0, core_wdata = 0;
   logic ext_req = 0, ext_we = 0;
   logic [31:0] ext_addr = 0, ext_wdata = 0;
   logic [3:0] ext_wmask = 0;
   logic [31:0] ram_rdata = 0;
   logic [31:0] core_rdata, ext_rdata, ram_wdata;
   logic core_stall_req, ext_gnt, ext_rvalid, ram_en, ram_we;
   logic [3:0] ram_wmask;
   logic [AW-1:0] ram_addr;
   logic [31:0] mem [0:4095];
   logic [31:0] shadow [0:4095];
   int n_cmp = 0, n_bad = 0;

   hb_ram_arbiter #(.RAM_AW(AW), .EXT_MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_sync(rst_sync),
      .core_read(core_read), .core_write(core_write), .core_write_width(core_write_width),
      .core_raddr(core_raddr), .core_waddr(core_waddr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_stall_req(core_stall_req),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wmask(ext_wmask),
      .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_wmask(ram_wmask), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else if (ram_en) ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic lanes(input logic [1:0] w, input logic [1:0] a, input logic [31:0] d,
                        output logic [3:0] m, output logic [31:0] q);
      m = 0;
      q = 0;
      for (int b = 0; b < 4; b++) begin
         if (w == 2'd0) begin
            m[b] = (b == int'(a));
            q[8*b +: 8] = d[7:0];
         end else if (w == 2'd1) begin
            m[b] = ((b / 2) == int'(a[1]));
            q[8*b +: 8] = d[8*(b%2) +: 8];
         end else begin
            m[b] = 1'b1;
            q[8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic put(input logic [AW-1:0] a, input logic [3:0] m, input logic [31:0] q);
      for (int b = 0; b < 4; b++)
         if (m[b]) shadow[a][8*b +: 8] = q[8*b +: 8];
   endtask

   // Model: pending read kind (1 core, 2 ext), consecutive ext denials, store-half-done flag
   int m_pend = 0, m_denied = 0;
   bit m_wpd = 0, cw;
   logic [31:0] m_data;
   logic e_en, e_we, e_gnt, e_rv, e_stall;
   logic [3:0] e_mask;
   logic [AW-1:0] e_addr;
   logic [31:0] e_wdata;

   always @(negedge clk) begin
      e_en = 0; e_we = 0; e_gnt = 0; e_rv = 0; e_stall = 0; e_mask = 0; e_addr = 0; e_wdata = 0;
      if (rst_sync) begin
         m_pend = 0; m_denied = 0; m_wpd = 0;
      end else if (m_pend != 0) begin
         if (m_pend == 1) chk("model_core_rdata", core_rdata, m_data);
         else begin
            e_rv = 1;
            e_stall = core_read | core_write;
            chk("model_ext_rdata", ext_rdata, m_data);
         end
         m_pend = 0;
         m_denied = ext_req ? (m_denied < MAXW ? m_denied + 1 : MAXW) : 0;
         m_wpd = m_wpd && core_read;
      end else begin
         cw = core_write && !m_wpd;
         if (ext_req && (m_denied >= MAXW || !(cw || core_read))) begin
            e_gnt = 1; e_en = 1; e_we = ext_we; e_addr = ext_addr[AW+1:2];
            e_stall = core_read | core_write;
            m_denied = 0;
            if (ext_we) begin
               e_mask = ext_wmask; e_wdata = ext_wdata;
               put(e_addr, e_mask, e_wdata);
            end else begin
               m_pend = 2; m_data = shadow[e_addr];
            end
            m_wpd = m_wpd && core_read;
         end else begin
            m_denied = ext_req ? (m_denied < MAXW ? m_denied + 1 : MAXW) : 0;
            if (cw) begin
               e_en = 1; e_we = 1; e_addr = core_waddr[AW+1:2];
               lanes(core_write_width, core_waddr[1:0], core_wdata, e_mask, e_wdata);
               put(e_addr, e_mask, e_wdata);
               e_stall = core_read;
               m_wpd = core_read;
            end else if (core_read) begin
               e_en = 1; e_addr = core_raddr[AW+1:2]; e_stall = 1;
               m_pend = 1; m_data = shadow[e_addr]; m_wpd = 0;
            end else m_wpd = 0;
         end
      end
      chk("model_ram_en", ram_en, e_en);
      chk("model_ext_gnt", ext_gnt, e_gnt);
      chk("model_ext_rvalid", ext_rvalid, e_rv);
      chk("model_stall", core_stall_req, e_stall);
      if (e_en) begin
         chk("model_ram_we", ram_we, e_we);
         chk("model_ram_addr", ram_addr, e_addr);
      end
      if (e_en && e_we) begin
         chk("model_ram_wmask", ram_wmask, e_mask);
         chk("model_ram_wdata", ram_wdata, e_wdata);
      end
   end

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      core_read = 0; core_write = 0; core_write_width = 0;
      core_raddr = 0; core_waddr = 0; core_wdata = 0;
      ext_req = 0; ext_we = 0; ext_addr = 0; ext_wmask = 0; ext_wdata = 0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = {i[15:0], ~i[15:0]};
         shadow[i] = {i[15:0], ~i[15:0]};
      end
      mem[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
      mem[8] = 32'hCAFEF00D; shadow[8] = 32'hCAFEF00D;
      nx(); nx();
      @(negedge clk);
      chk("reset_ram_en", ram_en, 0);
      chk("reset_ext_gnt", ext_gnt, 0);
      chk("reset_ext_rvalid", ext_rvalid, 0);
      nx(); rst_sync = 0;
      nx(); core_write = 1; core_write_width = 0; core_waddr = 32'h6; core_wdata = 32'hAB;
      @(negedge clk);
      chk("sb_we", ram_we, 1);
      chk("sb_mask", ram_wmask, 32'h4);
      chk("sb_wdata", ram_wdata, 32'hABABABAB);
      chk("sb_addr", ram_addr, 1);
      chk("sb_stall", core_stall_req, 0);
      nx(); clr(); core_read = 1; core_raddr = 32'h10;
      @(negedge clk);
      chk("lw_c0_stall", core_stall_req, 1);
      chk("lw_c0_addr", ram_addr, 4);
      nx();
      @(negedge clk);
      chk("lw_c1_stall", core_stall_req, 0);
      chk("lw_c1_rdata", core_rdata, 32'hDEADBEEF);
      chk("lw_c1_en", ram_en, 0);
      nx(); clr(); ext_req = 1; ext_addr = 32'h20;
      @(negedge clk);
      chk("extrd_gnt", ext_gnt, 1);
      nx(); clr();
      @(negedge clk);
      chk("extrd_rvalid", ext_rvalid, 1);
      chk("extrd_rdata", ext_rdata, 32'hCAFEF00D);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 5; i++) begin
            nx(); clr();
            core_write = 1; core_write_width = 2; core_waddr = 32'h100 + 4 * i; core_wdata = i + 16 * r;
            ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wmask = 4'b0110; ext_wdata = 32'h12345678 + r;
            @(negedge clk);
            chk("starve_gnt", ext_gnt, i == 4);
            chk("starve_stall", core_stall_req, i == 4);
         end
         nx(); ext_req = 0;
         @(negedge clk);
         chk("starve_after_stall", core_stall_req, 0);
         chk("starve_after_we", ram_we, 1);
      end
      nx(); clr(); core_read = 1; core_write = 1; core_write_width = 2;
      core_waddr = 32'h80; core_raddr = 32'h80; core_wdata = 32'h11223344;
      @(negedge clk);
      chk("rw0_we", ram_we, 1);
      chk("rw0_stall", core_stall_req, 1);
      nx();
      @(negedge clk);
      chk("rw1_en", ram_en, 1);
      chk("rw1_we", ram_we, 0);
      chk("rw1_stall", core_stall_req, 1);
      chk("rw1_addr", ram_addr, 32'h20);
      nx();
      @(negedge clk);
      chk("rw2_stall", core_stall_req, 0);
      chk("rw2_rdata", core_rdata, 32'h11223344);
      nx(); clr(); core_write = 1; core_write_width = 1; core_waddr = 32'h82; core_wdata = 32'h0000BEEF;
      @(negedge clk);
      chk("sh_mask", ram_wmask, 32'hC);
      chk("sh_wdata", ram_wdata, 32'hBEEFBEEF);
      nx(); clr(); ext_req = 1; ext_addr = 32'h100; core_read = 1; core_raddr = 32'h40;
      @(negedge clk);
      chk("ct0_gnt", ext_gnt, 0);
      chk("ct0_stall", core_stall_req, 1);
      nx();
      @(negedge clk);
      chk("ct1_stall", core_stall_req, 0);
      nx(); core_read = 0;
      @(negedge clk);
      chk("ct2_gnt", ext_gnt, 1);
      nx(); ext_req = 0; core_read = 1; core_raddr = 32'h10;
      @(negedge clk);
      chk("ct3_rvalid", ext_rvalid, 1);
      chk("ct3_stall", core_stall_req, 1);
      nx();
      @(negedge clk);
      chk("ct4_en", ram_en, 1);
      nx(); nx(); clr();
      nx(); core_read = 1; core_raddr = 32'h8;
      nx(); rst_sync = 1;
      @(negedge clk);
      chk("rstc_en", ram_en, 0);
      chk("rstc_stall", core_stall_req, 0);
      nx(); rst_sync = 0; clr();
      @(negedge clk);
      chk("rstc_idle_en", ram_en, 0);
      nx(); ext_req = 1; ext_addr = 32'h20;
      @(negedge clk);
      chk("rste_gnt", ext_gnt, 1);
      nx(); clr(); rst_sync = 1;
      @(negedge clk);
      chk("rste_rvalid", ext_rvalid, 0);
      nx(); rst_sync = 0;
      @(negedge clk);
      chk("rste_idle_rvalid", ext_rvalid, 0);
      chk("rste_idle_stall", core_stall_req, 0);
      nx(); nx(); nx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
